// File: rtl/motoro_uart_pkg.sv
// Shared definitions for the motor-controller UART command receiver:
// command byte codes, receiver FSM states and pulse-output selection.
package motoro_uart_pkg;

   localparam logic [7:0] CMD_START = 8'h53;
   localparam logic [7:0] CMD_STOP  = 8'h58;
   localparam logic [7:0] CMD_INV   = 8'h52;
   localparam logic [7:0] CMD_FINC  = 8'h2B;
   localparam logic [7:0] CMD_FDEC  = 8'h2D;
   localparam logic [7:0] CMD_PINC  = 8'h50;
   localparam logic [7:0] CMD_PDEC  = 8'h70;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rxState_t;

   typedef enum logic [2:0] {
      PULSE_NONE,
      PULSE_FINC,
      PULSE_FDEC,
      PULSE_PINC,
      PULSE_PDEC
   } pulseSel_t;

   function automatic pulseSel_t pulseOf(input logic [7:0] b);
      pulseSel_t sel;
      case (b)
         CMD_FINC: sel = PULSE_FINC;
         CMD_FDEC: sel = PULSE_FDEC;
         CMD_PINC: sel = PULSE_PINC;
         CMD_PDEC: sel = PULSE_PDEC;
         default:  sel = PULSE_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/motoro_uart_rx_byte.sv
// 8N1 byte deserialiser: RX synchroniser, bit-timing FSM and
// registered data/valid/frame-error strobes.
module motoro_uart_rx_byte
   import motoro_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
)(
   input  logic       clk50mhzI,
   input  logic       resetI,
   input  logic       uRxI,
   output logic [7:0] rxDataO,
   output logic       rxValidO,
   output logic       frameErrO
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic          rxMeta;
   logic          rxS;
   rxState_t      state;
   rxState_t      stateNext;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cntNext;
   logic [2:0]    bitIdx;
   logic [2:0]    bitIdxNext;
   logic [7:0]    shiftReg;
   logic [7:0]    shiftNext;
   logic [7:0]    dataNext;
   logic          validNext;
   logic          ferrNext;

   // Synchroniser idles high so reset never looks like a start bit
   always_ff @(posedge clk50mhzI) begin
      if (resetI) begin
         rxMeta <= 1'b1;
         rxS    <= 1'b1;
      end else begin
         rxMeta <= uRxI;
         rxS    <= rxMeta;
      end
   end

   always_ff @(posedge clk50mhzI) begin
      if (resetI) begin
         state <= RX_IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_ff @(posedge clk50mhzI) begin
      if (resetI) begin
         cnt       <= '0;
         bitIdx    <= '0;
         shiftReg  <= '0;
         rxDataO   <= '0;
         rxValidO  <= 1'b0;
         frameErrO <= 1'b0;
      end else begin
         cnt       <= cntNext;
         bitIdx    <= bitIdxNext;
         shiftReg  <= shiftNext;
         rxDataO   <= dataNext;
         rxValidO  <= validNext;
         frameErrO <= ferrNext;
      end
   end

   always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      bitIdxNext = bitIdx;
      shiftNext  = shiftReg;
      dataNext   = rxDataO;
      validNext  = 1'b0;
      ferrNext   = 1'b0;
      unique case (state)
         RX_IDLE: begin
            if (!rxS) begin
               stateNext  = RX_START;
               cntNext    = '0;
               bitIdxNext = '0;
            end
         end
         RX_START: begin
            if (cnt == HALF_LAST) begin
               cntNext   = '0;
               stateNext = rxS ? RX_IDLE : RX_DATA;
            end else begin
               cntNext = cnt + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt == BIT_LAST) begin
               cntNext    = '0;
               shiftNext  = {rxS, shiftReg[7:1]};
               bitIdxNext = bitIdx + 3'd1;
               if (bitIdx == 3'd7) begin
                  stateNext = RX_STOP;
               end
            end else begin
               cntNext = cnt + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt == BIT_LAST) begin
               cntNext   = '0;
               stateNext = RX_IDLE;
               if (rxS) begin
                  dataNext  = shiftReg;
                  validNext = 1'b1;
               end else begin
                  ferrNext = 1'b1;
               end
            end else begin
               cntNext = cnt + 1'b1;
            end
         end
         default: begin
            stateNext = RX_IDLE;
            cntNext   = '0;
         end
      endcase
   end

endmodule

// File: rtl/motoro_uart_cmd_rx.sv
// UART command receiver: decodes host bytes into motor-control levels
// and button-equivalent INC/DEC pulses.
module motoro_uart_cmd_rx
   import motoro_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int PULSE_CLKS   = 1000
)(
   input  logic       clk50mhzI,
   input  logic       resetI,
   input  logic       uRxI,
   output logic [7:0] rxDataO,
   output logic       rxValidO,
   output logic       frameErrO,
   output logic       cmdErrO,
   output logic       m3startO,
   output logic       m3forceStopO,
   output logic       m3invRotateO,
   output logic       m3freqINCo,
   output logic       m3freqDECo,
   output logic       m3powerINCo,
   output logic       m3powerDECo
);

   localparam int PW = $clog2(PULSE_CLKS + 1);
   localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CLKS);
   localparam logic [PW-1:0] PULSE_ONE  = PW'(1);

   pulseSel_t     cmdPulse;
   logic          cmdKnown;
   pulseSel_t     pulseSel;
   logic [PW-1:0] pulseCnt;

   motoro_uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) uRxByte (
      .clk50mhzI(clk50mhzI),
      .resetI   (resetI),
      .uRxI     (uRxI),
      .rxDataO  (rxDataO),
      .rxValidO (rxValidO),
      .frameErrO(frameErrO)
   );

   always_comb begin
      cmdPulse = pulseOf(rxDataO);
      cmdKnown = (cmdPulse != PULSE_NONE)
              || (rxDataO == CMD_START)
              || (rxDataO == CMD_STOP)
              || (rxDataO == CMD_INV);
   end

   always_ff @(posedge clk50mhzI) begin
      if (resetI) begin
         cmdErrO      <= 1'b0;
         m3startO     <= 1'b0;
         m3forceStopO <= 1'b0;
         m3invRotateO <= 1'b0;
      end else begin
         cmdErrO <= rxValidO && !cmdKnown;
         if (rxValidO) begin
            case (rxDataO)
               CMD_START: begin
                  m3startO     <= 1'b1;
                  m3forceStopO <= 1'b0;
               end
               CMD_STOP: begin
                  m3startO     <= 1'b0;
                  m3forceStopO <= 1'b1;
               end
               CMD_INV: m3invRotateO <= ~m3invRotateO;
               default: ;
            endcase
         end
      end
   end

   // One shared down-counter; a new or repeated command reloads it
   always_ff @(posedge clk50mhzI) begin
      if (resetI) begin
         pulseSel <= PULSE_NONE;
         pulseCnt <= '0;
      end else if (rxValidO && cmdPulse != PULSE_NONE) begin
         pulseSel <= cmdPulse;
         pulseCnt <= PULSE_LOAD;
      end else if (pulseCnt != '0) begin
         pulseCnt <= pulseCnt - PULSE_ONE;
         if (pulseCnt == PULSE_ONE) begin
            pulseSel <= PULSE_NONE;
         end
      end
   end

   assign m3freqINCo  = (pulseSel == PULSE_FINC);
   assign m3freqDECo  = (pulseSel == PULSE_FDEC);
   assign m3powerINCo = (pulseSel == PULSE_PINC);
   assign m3powerDECo = (pulseSel == PULSE_PDEC);

endmodule

// File: tb/tb_motoro_uart_cmd_rx.sv
// Directed bench for motoro_uart_cmd_rx; a second instance with long
// pulses exposes the same-cycle pulse hand-over between commands.
module tb_motoro_uart_cmd_rx;

   localparam int CPB  = 16;
   localparam int PCL  = 8;
   localparam int PCL2 = 300;

   logic clk = 1'b0;
   logic resetI = 1'b1;
   logic uRxI = 1'b1;

   logic [7:0] rxDataO;
   logic rxValidO, frameErrO, cmdErrO;
   logic m3startO, m3forceStopO, m3invRotateO;
   logic m3freqINCo, m3freqDECo, m3powerINCo, m3powerDECo;

   logic [7:0] rxData2;
   logic rxValid2, frameErr2, cmdErr2;
   logic start2, forceStop2, invRotate2;
   logic freqInc2, freqDec2, powerInc2, powerDec2;

   motoro_uart_cmd_rx #(.CLKS_PER_BIT(CPB), .PULSE_CLKS(PCL)) dut (
      .clk50mhzI(clk), .resetI(resetI), .uRxI(uRxI),
      .rxDataO(rxDataO), .rxValidO(rxValidO), .frameErrO(frameErrO),
      .cmdErrO(cmdErrO), .m3startO(m3startO),
      .m3forceStopO(m3forceStopO), .m3invRotateO(m3invRotateO),
      .m3freqINCo(m3freqINCo), .m3freqDECo(m3freqDECo),
      .m3powerINCo(m3powerINCo), .m3powerDECo(m3powerDECo)
   );

   motoro_uart_cmd_rx #(.CLKS_PER_BIT(CPB), .PULSE_CLKS(PCL2)) dut2 (
      .clk50mhzI(clk), .resetI(resetI), .uRxI(uRxI),
      .rxDataO(rxData2), .rxValidO(rxValid2), .frameErrO(frameErr2),
      .cmdErrO(cmdErr2), .m3startO(start2),
      .m3forceStopO(forceStop2), .m3invRotateO(invRotate2),
      .m3freqINCo(freqInc2), .m3freqDECo(freqDec2),
      .m3powerINCo(powerInc2), .m3powerDECo(powerDec2)
   );

   always #5 clk = ~clk;

   int nCmp = 0;
   int nErr = 0;
   int cyc = 0;
   int validCnt = 0, frameCnt = 0, cmdErrCnt = 0;
   int validCyc = 0, startRiseCyc = 0;
   logic [7:0] lastData = 8'h00;
   logic startPrev = 1'b0;
   logic [3:0] p1, p2;
   logic [3:0] prev1 = 4'b0, prev2 = 4'b0;
   int rise1[4], fall1[4], len1[4], riseN1[4];
   int rise2[4], fall2[4], len2[4];
   int overlap1 = 0, overlap2 = 0;

   assign p1 = {m3powerDECo, m3powerINCo, m3freqDECo, m3freqINCo};
   assign p2 = {powerDec2, powerInc2, freqDec2, freqInc2};

   always @(negedge clk) begin
      cyc++;
      if (rxValidO) begin
         validCnt++;
         validCyc = cyc;
         lastData = rxDataO;
      end
      if (frameErrO) frameCnt++;
      if (cmdErrO) cmdErrCnt++;
      if (m3startO && !startPrev) startRiseCyc = cyc;
      startPrev = m3startO;
      if ($countones(p1) > 1) overlap1++;
      if ($countones(p2) > 1) overlap2++;
      for (int i = 0; i < 4; i++) begin
         if (p1[i] && !prev1[i]) begin rise1[i] = cyc; riseN1[i]++; end
         if (!p1[i] && prev1[i]) begin fall1[i] = cyc; len1[i] = cyc - rise1[i]; end
         if (p2[i] && !prev2[i]) rise2[i] = cyc;
         if (!p2[i] && prev2[i]) begin fall2[i] = cyc; len2[i] = cyc - rise2[i]; end
      end
      prev1 = p1;
      prev2 = p2;
   end

   task automatic sendBit(input logic v);
      uRxI = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic sendByte(input logic [7:0] b, input logic stopBit);
      sendBit(1'b0);
      for (int i = 0; i < 8; i++) sendBit(b[i]);
      sendBit(stopBit);
      uRxI = 1'b1;
   endtask

   function automatic int riseSum();
      return riseN1[0] + riseN1[1] + riseN1[2] + riseN1[3];
   endfunction

   task automatic test_reset();
      resetI = 1'b1;
      repeat (3) @(posedge clk);
      #1 resetI = 1'b0;
      @(negedge clk);
      nCmp++;
      if ({rxDataO, rxValidO, frameErrO, cmdErrO, m3startO, m3forceStopO,
           m3invRotateO, p1} !== 19'h0) begin
         $display("FAIL reset_outputs got %h want 0", {rxDataO, rxValidO,
                  frameErrO, cmdErrO, m3startO, m3forceStopO, m3invRotateO, p1});
         nErr++;
      end
      nCmp++;
      if ({rxData2, start2, forceStop2, invRotate2, p2} !== 15'h0) begin
         $display("FAIL reset_dut2 got %h want 0", {rxData2, start2, forceStop2, invRotate2, p2});
         nErr++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_start_stop();
      int v0, c0;
      v0 = validCnt;
      c0 = cmdErrCnt;
      sendByte(8'h53, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      nCmp++;
      if (validCnt - v0 !== 1) begin
         $display("FAIL start_valid_count got %0d want 1", validCnt - v0); nErr++;
      end
      nCmp++;
      if (lastData !== 8'h53) begin
         $display("FAIL start_data got %h want 53", lastData); nErr++;
      end
      nCmp++;
      if (startRiseCyc !== validCyc + 1) begin
         $display("FAIL start_latency got %0d want %0d", startRiseCyc, validCyc + 1); nErr++;
      end
      nCmp++;
      if ({m3startO, m3forceStopO} !== 2'b10) begin
         $display("FAIL start_levels got %b want 10", {m3startO, m3forceStopO}); nErr++;
      end
      sendByte(8'h58, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      nCmp++;
      if ({m3startO, m3forceStopO} !== 2'b01) begin
         $display("FAIL stop_levels got %b want 01", {m3startO, m3forceStopO}); nErr++;
      end
      nCmp++;
      if (cmdErrCnt - c0 !== 0) begin
         $display("FAIL start_stop_cmderr got %0d want 0", cmdErrCnt - c0); nErr++;
      end
   endtask

   task automatic test_pulse();
      int r0, rs;
      r0 = riseN1[0];
      rs = riseSum();
      sendByte(8'h2B, 1'b1);
      repeat (30) @(posedge clk);
      #1;
      nCmp++;
      if (riseN1[0] - r0 !== 1) begin
         $display("FAIL finc_rises got %0d want 1", riseN1[0] - r0); nErr++;
      end
      nCmp++;
      if (len1[0] !== PCL) begin
         $display("FAIL finc_len got %0d want %0d", len1[0], PCL); nErr++;
      end
      nCmp++;
      if (riseSum() - rs !== 1) begin
         $display("FAIL finc_other_pulses got %0d want 1", riseSum() - rs); nErr++;
      end
      repeat (PCL2 + 20) @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int v0, r3;
      v0 = validCnt;
      r3 = riseN1[3];
      sendByte(8'h2B, 1'b1);
      sendByte(8'h70, 1'b1);
      repeat (PCL2 + 40) @(posedge clk);
      #1;
      nCmp++;
      if (validCnt - v0 !== 2) begin
         $display("FAIL b2b_valid_count got %0d want 2", validCnt - v0); nErr++;
      end
      nCmp++;
      if (lastData !== 8'h70) begin
         $display("FAIL b2b_data got %h want 70", lastData); nErr++;
      end
      nCmp++;
      if (riseN1[3] - r3 !== 1 || len1[3] !== PCL) begin
         $display("FAIL pdec_pulse got rises %0d len %0d want 1 len %0d",
                  riseN1[3] - r3, len1[3], PCL); nErr++;
      end
      nCmp++;
      if (fall2[0] !== rise2[3]) begin
         $display("FAIL handover got finc fall %0d want pdec rise %0d", fall2[0], rise2[3]); nErr++;
      end
      nCmp++;
      if (len2[3] !== PCL2) begin
         $display("FAIL long_pdec_len got %0d want %0d", len2[3], PCL2); nErr++;
      end
      nCmp++;
      if (overlap1 !== 0 || overlap2 !== 0) begin
         $display("FAIL pulse_overlap got %0d/%0d want 0", overlap1, overlap2); nErr++;
      end
   endtask

   task automatic test_rotate();
      sendByte(8'h52, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      nCmp++;
      if (m3invRotateO !== 1'b1) begin
         $display("FAIL rotate_first got %b want 1", m3invRotateO); nErr++;
      end
      sendByte(8'h52, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      nCmp++;
      if (m3invRotateO !== 1'b0) begin
         $display("FAIL rotate_second got %b want 0", m3invRotateO); nErr++;
      end
   endtask

   task automatic test_frame_err();
      int v0, f0, c0, rs;
      v0 = validCnt; f0 = frameCnt; c0 = cmdErrCnt; rs = riseSum();
      sendByte(8'h2B, 1'b0);
      repeat (60) @(posedge clk);
      #1;
      nCmp++;
      if (frameCnt - f0 !== 1 || validCnt - v0 !== 0) begin
         $display("FAIL frame_err got ferr %0d valid %0d want 1 0",
                  frameCnt - f0, validCnt - v0); nErr++;
      end
      nCmp++;
      if (rxDataO !== 8'h52) begin
         $display("FAIL frame_err_data got %h want 52", rxDataO); nErr++;
      end
      nCmp++;
      if (riseSum() - rs !== 0 || cmdErrCnt - c0 !== 0) begin
         $display("FAIL frame_err_side got pulses %0d cmderr %0d want 0 0",
                  riseSum() - rs, cmdErrCnt - c0); nErr++;
      end
   endtask

   task automatic test_glitch();
      int v0, f0;
      v0 = validCnt; f0 = frameCnt;
      uRxI = 1'b0;
      repeat (5) @(posedge clk);
      #1 uRxI = 1'b1;
      repeat (200) @(posedge clk);
      #1;
      nCmp++;
      if (validCnt - v0 !== 0 || frameCnt - f0 !== 0) begin
         $display("FAIL glitch got valid %0d ferr %0d want 0 0",
                  validCnt - v0, frameCnt - f0); nErr++;
      end
   endtask

   task automatic test_unknown();
      int v0, c0, rs;
      v0 = validCnt; c0 = cmdErrCnt; rs = riseSum();
      sendByte(8'h41, 1'b1);
      repeat (30) @(posedge clk);
      #1;
      nCmp++;
      if (validCnt - v0 !== 1 || lastData !== 8'h41) begin
         $display("FAIL unknown_rx got valid %0d data %h want 1 41",
                  validCnt - v0, lastData); nErr++;
      end
      nCmp++;
      if (cmdErrCnt - c0 !== 1) begin
         $display("FAIL unknown_cmderr got %0d want 1", cmdErrCnt - c0); nErr++;
      end
      nCmp++;
      if ({m3startO, m3forceStopO, m3invRotateO} !== 3'b010 || riseSum() - rs !== 0) begin
         $display("FAIL unknown_levels got %b pulses %0d want 010 0",
                  {m3startO, m3forceStopO, m3invRotateO}, riseSum() - rs); nErr++;
      end
   endtask

   task automatic test_reset_mid();
      int v0, f0;
      logic [7:0] b;
      b = 8'h53;
      v0 = validCnt; f0 = frameCnt;
      sendBit(1'b0);
      for (int i = 0; i < 4; i++) sendBit(b[i]);
      resetI = 1'b1;
      uRxI = 1'b1;
      repeat (2) @(posedge clk);
      #1 resetI = 1'b0;
      @(negedge clk);
      nCmp++;
      if ({rxDataO, rxValidO, frameErrO, cmdErrO, m3startO, m3forceStopO,
           m3invRotateO, p1} !== 19'h0) begin
         $display("FAIL midreset_outputs got %h want 0", {rxDataO, rxValidO,
                  frameErrO, cmdErrO, m3startO, m3forceStopO, m3invRotateO, p1});
         nErr++;
      end
      repeat (200) @(posedge clk);
      #1;
      nCmp++;
      if (validCnt - v0 !== 0 || frameCnt - f0 !== 0) begin
         $display("FAIL midreset_strobes got valid %0d ferr %0d want 0 0",
                  validCnt - v0, frameCnt - f0); nErr++;
      end
      sendByte(8'h53, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      nCmp++;
      if (validCnt - v0 !== 1 || lastData !== 8'h53 || m3startO !== 1'b1) begin
         $display("FAIL midreset_recover got valid %0d data %h start %b want 1 53 1",
                  validCnt - v0, lastData, m3startO); nErr++;
      end
   endtask

   initial begin
      test_reset();
      test_start_stop();
      test_pulse();
      test_back_to_back();
      test_rotate();
      test_frame_err();
      test_glitch();
      test_unknown();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
